nv_nvdla_cacc_csb2reg: RTL and testbench
========================================

NV_NVDLA_CACC_CSB2REG -- requirements
Module: nv_nvdla_cacc_csb2reg

Interface
REQ-001 SHALL: one clock; reset is asynchronous and active-low (nvdla_core_clk, nvdla_core_rstn).
REQ-002 SHALL: param GRP_BASE, default 16'h9000, CACC byte-address window base (4 KB).
REQ-003 SHALL: param SINGLE_TOP, default 12'h008, first dual-group offset; offsets below it go to the single group.
REQ-004 SHALL: nvdla_core_clk  in  1  clock.
REQ-005 SHALL: nvdla_core_rstn  in  1  async active-low reset.
REQ-006 SHALL: csb2cacc_req_pvld  in  1  request valid.
REQ-007 SHALL: csb2cacc_req_prdy  out  1  request ready.
REQ-008 SHALL: csb2cacc_req_pd  in  63  [21:0] word addr, [53:22] wdat, [54] write, [55] nposted, [62:56] ignored.
REQ-009 SHALL: cacc2csb_resp_valid  out  1  response strobe; no backpressure.
REQ-010 SHALL: cacc2csb_resp_pd  out  34  [31:0] rdata, [32] error, [33] 1=write ack / 0=read data.
REQ-011 SHALL: reg_offset  out  12  byte offset to all register groups.
REQ-012 SHALL: reg_wr_data  out  32  write data.
REQ-013 SHALL: s_reg_wr_en, d0_reg_wr_en, d1_reg_wr_en  out  1 each  write strobes.
REQ-014 SHALL: s_reg_rd_data, d0_reg_rd_data, d1_reg_rd_data  in  32 each  combinational read data.
REQ-015 SHALL: producer  in  1  dual-group select (0=d0, 1=d1).

Function
REQ-016 SHALL: FSM states IDLE, ACC, RESP; reset state IDLE.
REQ-017 SHALL: req_prdy = 1 only in IDLE; pvld&prdy latches pd and goes to ACC.
REQ-018 SHALL: byte address = {req addr, 2'b00}; in range iff byte_addr[23:12] == GRP_BASE[15:12] and byte_addr[31:24] == 0.
REQ-019 SHALL: in ACC, reg_offset = byte_addr[11:0] and reg_wr_data = wdat, held until next ACC.
REQ-020 SHALL: in ACC, for an in-range write, pulse exactly one wr_en for one cycle: s if offset < SINGLE_TOP, else d0/d1 per producer sampled in ACC.
REQ-021 SHALL: in ACC, for a read, capture from the same group selection into resp data register.
REQ-022 SHALL: ACC -> RESP if read or nposted write; ACC -> IDLE for posted write.
REQ-023 SHALL: RESP drives resp_valid high for exactly one cycle, then IDLE.
REQ-024 SHALL: out-of-range access asserts no wr_en; read data = 0; error per REQ-030/031.
REQ-025 SHALL: min spacing 2 cycles (posted write), 3 cycles (read or nposted write) between accepted requests.
REQ-026 SHALL: producer toggle during ACC uses the ACC-cycle value; prior accesses are unaffected.
REQ-027 SHALL: write ack resp_pd[31:0] = 0.

Reset
REQ-028 SHALL: async assert clears FSM to IDLE; prdy=1, resp_valid=0, resp_pd=0, reg_offset=0, reg_wr_data=0, all wr_en=0.
REQ-029 SHALL: reset in ACC/RESP abandons the request with no strobe and no response after deassertion.

Configuration
REQ-030 SHALL: with NVDLA_CACC_CSB_ERR_RESP_EN defined, out-of-range read/nposted write responds with error=1.
REQ-031 SHALL: without NVDLA_CACC_CSB_ERR_RESP_EN, error bit is tied 0; out-of-range still responds with data 0 and no wr_en.

Structure
REQ-032 SHALL: shared package nv_nvdla_cacc_csb_pkg holds FSM state enum, pd field bit positions, and response type constants.
REQ-033 SHALL: one sub-module, nv_nvdla_cacc_csb_resp, holds the response register and one-cycle valid generation.

Verification
REQ-034 SHALL: read addr 0x2404 (byte 0x9010), producer=1, d1_reg_rd_data=0x0123_0456 -> resp_valid 3 cycles after accept, pd={1'b0,1'b0,0x01230456}.
REQ-035 SHALL: posted write addr 0x2402 (byte 0x9008), wdat=1, producer=0 -> d0_reg_wr_en one cycle, reg_offset=0x008, no response.
REQ-036 SHALL: nposted write byte 0x9004 -> s_reg_wr_en pulses once, then resp pd[33]=1, pd[32]=0, data 0.
REQ-037 SHALL: read byte 0xA000 -> no wr_en; resp error=1 with macro, 0 without; data 0.
REQ-038 SHALL: pvld held high for back-to-back reads -> prdy low in ACC/RESP, accepts spaced exactly 3 cycles, none dropped.
REQ-039 SHALL: rstn asserted in ACC of a write -> no wr_en, no resp, prdy=1 one cycle after release.

Source files
------------

// File: rtl/nv_nvdla_cacc_csb_pkg.sv
// Shared definitions for the CACC CSB register front-end: FSM states,
// request payload field positions and response payload layout.
package nv_nvdla_cacc_csb_pkg;

  typedef enum logic [1:0] {
    CSB_IDLE = 2'd0,
    CSB_ACC  = 2'd1,
    CSB_RESP = 2'd2
  } csb_state_e;

  localparam int PD_WIDTH       = 63;
  localparam int PD_ADDR_LSB    = 0;
  localparam int PD_ADDR_W      = 22;
  localparam int PD_WDAT_LSB    = 22;
  localparam int PD_WDAT_W      = 32;
  localparam int PD_WRITE_BIT   = 54;
  localparam int PD_NPOSTED_BIT = 55;

  localparam int RESP_WIDTH    = 34;
  localparam int RESP_ERR_BIT  = 32;
  localparam int RESP_TYPE_BIT = 33;

  localparam logic RESP_TYPE_READ  = 1'b0;
  localparam logic RESP_TYPE_WRITE = 1'b1;

  function automatic logic [RESP_WIDTH-1:0] pack_resp(input logic        resp_type,
                                                      input logic        err,
                                                      input logic [31:0] data);
    return {resp_type, err, data};
  endfunction

endpackage

// File: rtl/nv_nvdla_cacc_csb2reg_if.sv
// CSB request/response channel between the CSB master and the CACC
// register front-end.
interface nv_nvdla_cacc_csb2reg_if;
  import nv_nvdla_cacc_csb_pkg::*;

  logic                  csb2cacc_req_pvld;
  logic                  csb2cacc_req_prdy;
  logic [PD_WIDTH-1:0]   csb2cacc_req_pd;
  logic                  cacc2csb_resp_valid;
  logic [RESP_WIDTH-1:0] cacc2csb_resp_pd;

  modport master (
    output csb2cacc_req_pvld,
    output csb2cacc_req_pd,
    input  csb2cacc_req_prdy,
    input  cacc2csb_resp_valid,
    input  cacc2csb_resp_pd
  );

  modport slave (
    input  csb2cacc_req_pvld,
    input  csb2cacc_req_pd,
    output csb2cacc_req_prdy,
    output cacc2csb_resp_valid,
    output cacc2csb_resp_pd
  );

endinterface

// File: rtl/nv_nvdla_cacc_csb_resp.sv
// Response register for the CACC CSB front-end: captures the payload during
// the access cycle and emits a single-cycle response strobe.
module nv_nvdla_cacc_csb_resp
  import nv_nvdla_cacc_csb_pkg::*;
(
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  capture,
  input  logic                  fire,
  input  logic                  is_write,
  input  logic                  err,
  input  logic [31:0]           rd_data,
  output logic                  resp_valid,
  output logic [RESP_WIDTH-1:0] resp_pd
);

  // Payload holds until the next captured access so it is stable while valid is high.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      resp_valid <= 1'b0;
      resp_pd    <= '0;
    end else begin
      resp_valid <= fire;
      if (capture) begin
        resp_pd <= pack_resp(is_write ? RESP_TYPE_WRITE : RESP_TYPE_READ,
                             err,
                             is_write ? 32'h0 : rd_data);
      end
    end
  end

endmodule

// File: rtl/nv_nvdla_cacc_csb2reg.sv
// CSB slave front-end for the CACC single and dual register groups.
// Optional macro NVDLA_CACC_CSB_ERR_RESP_EN reports out-of-window accesses with error=1.
module nv_nvdla_cacc_csb2reg
  import nv_nvdla_cacc_csb_pkg::*;
#(
  parameter logic [15:0] GRP_BASE   = 16'h9000,
  parameter logic [11:0] SINGLE_TOP = 12'h008
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  nv_nvdla_cacc_csb2reg_if.slave csb,
  output logic [11:0]            reg_offset,
  output logic [31:0]            reg_wr_data,
  output logic                   s_reg_wr_en,
  output logic                   d0_reg_wr_en,
  output logic                   d1_reg_wr_en,
  input  logic [31:0]            s_reg_rd_data,
  input  logic [31:0]            d0_reg_rd_data,
  input  logic [31:0]            d1_reg_rd_data,
  input  logic                   producer
);

  localparam logic [11:0] GRP_PAGE = {8'h00, GRP_BASE[15:12]};

  csb_state_e  state;
  csb_state_e  state_nxt;
  logic        req_prdy;
  logic        accept;
  logic [23:0] byte_addr_q;
  logic        is_write_q;
  logic        nposted_q;
  logic        in_range;
  logic        single_sel;
  logic        need_resp;
  logic        wr_hit;
  logic        resp_err;
  logic        resp_capture;
  logic        resp_fire;
  logic [31:0] rd_data_sel;
  logic        unused_pd_bits;

  assign unused_pd_bits        = ^csb.csb2cacc_req_pd[PD_WIDTH-1:PD_NPOSTED_BIT+1];
  assign accept                = csb.csb2cacc_req_pvld & req_prdy;
  assign csb.csb2cacc_req_prdy = req_prdy;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state <= CSB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      byte_addr_q <= '0;
      reg_wr_data <= '0;
      is_write_q  <= 1'b0;
      nposted_q   <= 1'b0;
    end else if (accept) begin
      byte_addr_q <= {csb.csb2cacc_req_pd[PD_ADDR_LSB +: PD_ADDR_W], 2'b00};
      reg_wr_data <= csb.csb2cacc_req_pd[PD_WDAT_LSB +: PD_WDAT_W];
      is_write_q  <= csb.csb2cacc_req_pd[PD_WRITE_BIT];
      nposted_q   <= csb.csb2cacc_req_pd[PD_NPOSTED_BIT];
    end
  end

  // A 22-bit word address gives a 24-bit byte address, so bits [31:24] are zero by construction.
  assign reg_offset   = byte_addr_q[11:0];
  assign in_range     = (byte_addr_q[23:12] == GRP_PAGE);
  assign single_sel   = (reg_offset < SINGLE_TOP);
  assign need_resp    = ~is_write_q | nposted_q;
  assign wr_hit       = (state == CSB_ACC) & is_write_q & in_range;
  assign resp_capture = (state == CSB_ACC) & need_resp;
  assign resp_fire    = (state == CSB_RESP);

  // producer is used live here, so the ACC-cycle value steers both writes and read capture.
  always_comb begin
    s_reg_wr_en  = 1'b0;
    d0_reg_wr_en = 1'b0;
    d1_reg_wr_en = 1'b0;
    rd_data_sel  = '0;
    if (in_range) begin
      if (single_sel) begin
        rd_data_sel = s_reg_rd_data;
      end else if (producer) begin
        rd_data_sel = d1_reg_rd_data;
      end else begin
        rd_data_sel = d0_reg_rd_data;
      end
    end
    if (wr_hit) begin
      if (single_sel) begin
        s_reg_wr_en = 1'b1;
      end else if (producer) begin
        d1_reg_wr_en = 1'b1;
      end else begin
        d0_reg_wr_en = 1'b1;
      end
    end
  end

`ifdef NVDLA_CACC_CSB_ERR_RESP_EN
  assign resp_err = ~in_range;
`else
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    req_prdy  = 1'b0;
    case (state)
      CSB_IDLE: begin
        req_prdy = 1'b1;
        if (csb.csb2cacc_req_pvld) begin
          state_nxt = CSB_ACC;
        end
      end
      CSB_ACC:  state_nxt = need_resp ? CSB_RESP : CSB_IDLE;
      CSB_RESP: state_nxt = CSB_IDLE;
      default:  state_nxt = CSB_IDLE;
    endcase
  end

  nv_nvdla_cacc_csb_resp u_resp (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .capture         (resp_capture),
    .fire            (resp_fire),
    .is_write        (is_write_q),
    .err             (resp_err),
    .rd_data         (rd_data_sel),
    .resp_valid      (csb.cacc2csb_resp_valid),
    .resp_pd         (csb.cacc2csb_resp_pd)
  );

endmodule

// File: tb/tb_nv_nvdla_cacc_csb2reg.sv
// Self-checking bench for nv_nvdla_cacc_csb2reg: directed and randomized CSB
// accesses compared against a transaction-level model of the register window.
module tb_nv_nvdla_cacc_csb2reg;

  logic        nvdla_core_clk  = 1'b0;
  logic        nvdla_core_rstn = 1'b1;
  logic [11:0] reg_offset;
  logic [31:0] reg_wr_data;
  logic        s_reg_wr_en;
  logic        d0_reg_wr_en;
  logic        d1_reg_wr_en;
  logic [31:0] s_reg_rd_data  = '0;
  logic [31:0] d0_reg_rd_data = '0;
  logic [31:0] d1_reg_rd_data = '0;
  logic        producer       = 1'b0;

  int chk_pass  = 0;
  int chk_total = 0;

`ifdef NVDLA_CACC_CSB_ERR_RESP_EN
  localparam logic OOR_ERR = 1'b1;
`else
  localparam logic OOR_ERR = 1'b0;
`endif

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  nv_nvdla_cacc_csb2reg_if csb ();

  nv_nvdla_cacc_csb2reg dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .csb             (csb),
    .reg_offset      (reg_offset),
    .reg_wr_data     (reg_wr_data),
    .s_reg_wr_en     (s_reg_wr_en),
    .d0_reg_wr_en    (d0_reg_wr_en),
    .d1_reg_wr_en    (d1_reg_wr_en),
    .s_reg_rd_data   (s_reg_rd_data),
    .d0_reg_rd_data  (d0_reg_rd_data),
    .d1_reg_rd_data  (d1_reg_rd_data),
    .producer        (producer)
  );

  typedef struct packed {
    logic [2:0]  wr;
    logic        has_resp;
    logic [33:0] pd;
    logic [11:0] offset;
  } exp_t;

  // Transaction-level model: a 4 KB window at 0x9000, first 8 bytes single group.
  function automatic exp_t model(input logic [21:0] addr, input logic write, input logic nposted,
                                 input logic prod, input logic [31:0] srd, input logic [31:0] d0rd,
                                 input logic [31:0] d1rd);
    exp_t        e;
    int unsigned byte_addr;
    int unsigned offset;
    logic        in_range;
    logic [31:0] data;
    logic        err;
    byte_addr = 32'(addr) * 4;
    in_range  = (byte_addr >= 32'h9000) && (byte_addr < 32'hA000);
    offset    = byte_addr % 4096;
    e.offset  = offset[11:0];
    e.wr      = 3'b000;
    if (offset < 8)  data = srd;
    else if (prod)   data = d1rd;
    else             data = d0rd;
    if (write && in_range) e.wr = (offset < 8) ? 3'b001 : (prod ? 3'b100 : 3'b010);
    if (!in_range || write) data = 32'h0;
    err        = in_range ? 1'b0 : OOR_ERR;
    e.has_resp = !write || nposted;
    e.pd       = {write, err, data};
    return e;
  endfunction

  logic [2:0]  obs_wr_acc;
  int          obs_wr_total;
  int          obs_resp_cnt;
  int          obs_resp_k;
  logic [33:0] obs_resp_pd;
  logic [11:0] obs_offset;
  logic [31:0] obs_wdata;
  logic        obs_prdy_acc;
  int          obs_prdy_k;
  bit          obs_timeout;

  // Drives one request, then records strobes and responses over the following four cycles.
  task automatic do_txn(input logic [21:0] addr, input logic [31:0] wdat, input logic write,
                        input logic nposted, input logic prod, input logic [31:0] srd,
                        input logic [31:0] d0rd, input logic [31:0] d1rd);
    int         wait_cnt;
    logic [2:0] wr;
    obs_wr_acc   = '0;
    obs_wr_total = 0;
    obs_resp_cnt = 0;
    obs_resp_k   = -1;
    obs_resp_pd  = '0;
    obs_offset   = '0;
    obs_wdata    = '0;
    obs_prdy_acc = 1'b1;
    obs_prdy_k   = -1;
    obs_timeout  = 0;
    @(posedge nvdla_core_clk); #1;
    producer                  = prod;
    s_reg_rd_data             = srd;
    d0_reg_rd_data            = d0rd;
    d1_reg_rd_data            = d1rd;
    csb.csb2cacc_req_pd       = {7'($urandom), nposted, write, wdat, addr};
    csb.csb2cacc_req_pvld     = 1'b1;
    wait_cnt = 0;
    @(negedge nvdla_core_clk);
    while (!csb.csb2cacc_req_prdy && wait_cnt < 10) begin
      @(negedge nvdla_core_clk);
      wait_cnt++;
    end
    if (!csb.csb2cacc_req_prdy) begin
      obs_timeout = 1;
      csb.csb2cacc_req_pvld = 1'b0;
      return;
    end
    for (int k = 1; k <= 4; k++) begin
      @(posedge nvdla_core_clk); #1;
      if (k == 1) csb.csb2cacc_req_pvld = 1'b0;
      if (k == 2) begin
        producer       = ~prod;
        s_reg_rd_data  = $urandom;
        d0_reg_rd_data = $urandom;
        d1_reg_rd_data = $urandom;
      end
      @(negedge nvdla_core_clk);
      wr = {d1_reg_wr_en, d0_reg_wr_en, s_reg_wr_en};
      obs_wr_total += $countones(wr);
      if (k == 1) begin
        obs_wr_acc   = wr;
        obs_offset   = reg_offset;
        obs_wdata    = reg_wr_data;
        obs_prdy_acc = csb.csb2cacc_req_prdy;
      end
      if (csb.cacc2csb_resp_valid) begin
        obs_resp_cnt++;
        if (obs_resp_k < 0) begin
          obs_resp_k  = k;
          obs_resp_pd = csb.cacc2csb_resp_pd;
        end
      end
      if (csb.csb2cacc_req_prdy && obs_prdy_k < 0) obs_prdy_k = k;
    end
  endtask

  task automatic test_reset();
    csb.csb2cacc_req_pvld = 1'b0;
    csb.csb2cacc_req_pd   = '0;
    #2 nvdla_core_rstn = 1'b0;
    @(negedge nvdla_core_clk);
    chk_total++;
    if (csb.csb2cacc_req_prdy !== 1'b1) $display("[TB] FAIL reset_prdy got %b exp 1", csb.csb2cacc_req_prdy);
    else chk_pass++;
    chk_total++;
    if (csb.cacc2csb_resp_valid !== 1'b0) $display("[TB] FAIL reset_resp_valid got %b exp 0", csb.cacc2csb_resp_valid);
    else chk_pass++;
    chk_total++;
    if (csb.cacc2csb_resp_pd !== 34'h0) $display("[TB] FAIL reset_resp_pd got %h exp 0", csb.cacc2csb_resp_pd);
    else chk_pass++;
    chk_total++;
    if (reg_offset !== 12'h0) $display("[TB] FAIL reset_offset got %h exp 0", reg_offset);
    else chk_pass++;
    chk_total++;
    if (reg_wr_data !== 32'h0) $display("[TB] FAIL reset_wr_data got %h exp 0", reg_wr_data);
    else chk_pass++;
    chk_total++;
    if ({d1_reg_wr_en, d0_reg_wr_en, s_reg_wr_en} !== 3'b000)
      $display("[TB] FAIL reset_wr_en got %b exp 000", {d1_reg_wr_en, d0_reg_wr_en, s_reg_wr_en});
    else chk_pass++;
    @(posedge nvdla_core_clk); #1;
    nvdla_core_rstn = 1'b1;
    repeat (2) @(posedge nvdla_core_clk);
  endtask

  task automatic test_directed();
    do_txn(22'h2404, 32'h0, 1'b0, 1'b0, 1'b1, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0123_0456);
    chk_total++;
    if (obs_timeout || obs_resp_pd !== 34'h0_0123_0456)
      $display("[TB] FAIL read_d1_pd got %h exp %h (timeout %0d)", obs_resp_pd, 34'h0_0123_0456, obs_timeout);
    else chk_pass++;
    chk_total++;
    if (obs_resp_k !== 3 || obs_resp_cnt !== 1)
      $display("[TB] FAIL read_d1_latency got k=%0d cnt=%0d exp k=3 cnt=1", obs_resp_k, obs_resp_cnt);
    else chk_pass++;

    do_txn(22'h2402, 32'h1, 1'b1, 1'b0, 1'b0, $urandom, $urandom, $urandom);
    chk_total++;
    if (obs_timeout || obs_wr_acc !== 3'b010 || obs_wr_total !== 1)
      $display("[TB] FAIL posted_wr_d0 got wr=%b total=%0d exp wr=010 total=1", obs_wr_acc, obs_wr_total);
    else chk_pass++;
    chk_total++;
    if (obs_offset !== 12'h008 || obs_wdata !== 32'h1)
      $display("[TB] FAIL posted_wr_fields got off=%h wd=%h exp off=008 wd=1", obs_offset, obs_wdata);
    else chk_pass++;
    chk_total++;
    if (obs_resp_cnt !== 0 || obs_prdy_k !== 2)
      $display("[TB] FAIL posted_wr_noresp got cnt=%0d prdy_k=%0d exp cnt=0 prdy_k=2", obs_resp_cnt, obs_prdy_k);
    else chk_pass++;

    do_txn(22'h2401, 32'h5A5A_5A5A, 1'b1, 1'b1, 1'b1, $urandom, $urandom, $urandom);
    chk_total++;
    if (obs_timeout || obs_wr_acc !== 3'b001 || obs_wr_total !== 1)
      $display("[TB] FAIL nposted_wr_s got wr=%b total=%0d exp wr=001 total=1", obs_wr_acc, obs_wr_total);
    else chk_pass++;
    chk_total++;
    if (obs_resp_pd !== 34'h2_0000_0000 || obs_resp_k !== 3)
      $display("[TB] FAIL nposted_wr_ack got pd=%h k=%0d exp pd=200000000 k=3", obs_resp_pd, obs_resp_k);
    else chk_pass++;

    do_txn(22'h2800, 32'h0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_total++;
    if (obs_timeout || obs_wr_total !== 0)
      $display("[TB] FAIL oor_read_wr got total=%0d exp 0", obs_wr_total);
    else chk_pass++;
    chk_total++;
    if (obs_resp_pd !== {1'b0, OOR_ERR, 32'h0} || obs_resp_k !== 3)
      $display("[TB] FAIL oor_read_pd got pd=%h k=%0d exp pd=%h k=3", obs_resp_pd, obs_resp_k, {1'b0, OOR_ERR, 32'h0});
    else chk_pass++;
  endtask

  task automatic test_random();
    logic [21:0] addr;
    logic [31:0] wdat;
    logic [31:0] srd;
    logic [31:0] d0rd;
    logic [31:0] d1rd;
    logic        write;
    logic        nposted;
    logic        prod;
    exp_t        e;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: addr = 22'h2400 + 22'($urandom_range(0, 15));
        3:       addr = 22'h2400 + 22'($urandom_range(0, 1023));
        4:       addr = 22'($urandom);
        default: addr = ($urandom_range(0, 1) == 1) ? 22'h23FF : 22'h2800;
      endcase
      write   = 1'($urandom_range(0, 1));
      nposted = 1'($urandom_range(0, 1));
      prod    = 1'($urandom_range(0, 1));
      wdat    = $urandom;
      srd     = $urandom;
      d0rd    = $urandom;
      d1rd    = $urandom;
      e = model(addr, write, nposted, prod, srd, d0rd, d1rd);
      do_txn(addr, wdat, write, nposted, prod, srd, d0rd, d1rd);
      chk_total++;
      if (obs_timeout || obs_wr_acc !== e.wr || obs_wr_total !== $countones(e.wr))
        $display("[TB] FAIL rand_wr addr=%h got wr=%b total=%0d exp wr=%b", addr, obs_wr_acc, obs_wr_total, e.wr);
      else chk_pass++;
      chk_total++;
      if (obs_offset !== e.offset || obs_wdata !== wdat)
        $display("[TB] FAIL rand_fields addr=%h got off=%h wd=%h exp off=%h wd=%h", addr, obs_offset, obs_wdata, e.offset, wdat);
      else chk_pass++;
      chk_total++;
      if (obs_resp_cnt !== (e.has_resp ? 1 : 0) || obs_prdy_k !== (e.has_resp ? 3 : 2) || obs_prdy_acc !== 1'b0)
        $display("[TB] FAIL rand_timing addr=%h got resp=%0d prdy_k=%0d exp resp=%0d prdy_k=%0d",
                 addr, obs_resp_cnt, obs_prdy_k, e.has_resp ? 1 : 0, e.has_resp ? 3 : 2);
      else chk_pass++;
      if (e.has_resp) begin
        chk_total++;
        if (obs_resp_pd !== e.pd || obs_resp_k !== 3)
          $display("[TB] FAIL rand_resp addr=%h got pd=%h k=%0d exp pd=%h k=3", addr, obs_resp_pd, obs_resp_k, e.pd);
        else chk_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] addrs [4];
    logic [33:0] exp_q [$];
    exp_t        e;
    int          accepted;
    int          responses;
    int          last_acc;
    int          prdy_low;
    bit          advance;
    addrs[0] = 22'h2401;
    addrs[1] = 22'h2403;
    addrs[2] = 22'h2800;
    addrs[3] = 22'h2405;
    accepted  = 0;
    responses = 0;
    last_acc  = 0;
    prdy_low  = 0;
    @(posedge nvdla_core_clk); #1;
    producer              = 1'($urandom_range(0, 1));
    s_reg_rd_data         = $urandom;
    d0_reg_rd_data        = $urandom;
    d1_reg_rd_data        = $urandom;
    csb.csb2cacc_req_pd   = {7'h0, 1'b0, 1'b0, 32'h0, addrs[0]};
    csb.csb2cacc_req_pvld = 1'b1;
    for (int cyc = 0; cyc < 40 && !(accepted == 4 && responses == 4); cyc++) begin
      @(negedge nvdla_core_clk);
      advance = 0;
      if (csb.cacc2csb_resp_valid) begin
        responses++;
        chk_total++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL b2b_resp_extra got pd=%h exp none", csb.cacc2csb_resp_pd);
        end else begin
          if (csb.cacc2csb_resp_pd !== exp_q[0])
            $display("[TB] FAIL b2b_resp_pd got %h exp %h", csb.cacc2csb_resp_pd, exp_q[0]);
          else chk_pass++;
          void'(exp_q.pop_front());
        end
      end
      if (csb.csb2cacc_req_pvld && csb.csb2cacc_req_prdy) begin
        if (accepted > 0) begin
          chk_total++;
          if (cyc - last_acc !== 3) $display("[TB] FAIL b2b_spacing got %0d exp 3", cyc - last_acc);
          else chk_pass++;
        end
        e = model(addrs[accepted], 1'b0, 1'b0, producer, s_reg_rd_data, d0_reg_rd_data, d1_reg_rd_data);
        exp_q.push_back(e.pd);
        last_acc = cyc;
        accepted++;
        advance = 1;
      end
      if (!csb.csb2cacc_req_prdy) prdy_low++;
      @(posedge nvdla_core_clk); #1;
      if (advance) begin
        if (accepted < 4) csb.csb2cacc_req_pd = {7'h0, 1'b0, 1'b0, 32'h0, addrs[accepted]};
        else csb.csb2cacc_req_pvld = 1'b0;
      end
    end
    csb.csb2cacc_req_pvld = 1'b0;
    chk_total++;
    if (accepted !== 4 || responses !== 4)
      $display("[TB] FAIL b2b_count got acc=%0d resp=%0d exp 4/4", accepted, responses);
    else chk_pass++;
    chk_total++;
    if (prdy_low !== 8) $display("[TB] FAIL b2b_prdy_low got %0d exp 8", prdy_low);
    else chk_pass++;
  endtask

  task automatic test_reset_in_acc();
    int wait_cnt;
    int wr_cnt;
    int resp_cnt;
    @(posedge nvdla_core_clk); #1;
    producer              = 1'b0;
    csb.csb2cacc_req_pd   = {7'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 22'h2405};
    csb.csb2cacc_req_pvld = 1'b1;
    wait_cnt = 0;
    @(negedge nvdla_core_clk);
    while (!csb.csb2cacc_req_prdy && wait_cnt < 10) begin
      @(negedge nvdla_core_clk);
      wait_cnt++;
    end
    chk_total++;
    if (!csb.csb2cacc_req_prdy) $display("[TB] FAIL rst_acc_accept got prdy=0 exp 1");
    else chk_pass++;
    @(posedge nvdla_core_clk); #1;
    csb.csb2cacc_req_pvld = 1'b0;
    nvdla_core_rstn       = 1'b0;
    @(negedge nvdla_core_clk);
    chk_total++;
    if ({d1_reg_wr_en, d0_reg_wr_en, s_reg_wr_en} !== 3'b000 || reg_offset !== 12'h0 || reg_wr_data !== 32'h0)
      $display("[TB] FAIL rst_acc_clear got wr=%b off=%h wd=%h exp 000/0/0",
               {d1_reg_wr_en, d0_reg_wr_en, s_reg_wr_en}, reg_offset, reg_wr_data);
    else chk_pass++;
    @(posedge nvdla_core_clk); #1;
    nvdla_core_rstn = 1'b1;
    wr_cnt   = 0;
    resp_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge nvdla_core_clk);
      if (k == 0) begin
        chk_total++;
        if (csb.csb2cacc_req_prdy !== 1'b1) $display("[TB] FAIL rst_acc_prdy got %b exp 1", csb.csb2cacc_req_prdy);
        else chk_pass++;
      end
      wr_cnt   += $countones({d1_reg_wr_en, d0_reg_wr_en, s_reg_wr_en});
      resp_cnt += csb.cacc2csb_resp_valid ? 1 : 0;
    end
    chk_total++;
    if (wr_cnt !== 0 || resp_cnt !== 0)
      $display("[TB] FAIL rst_acc_abandon got wr=%0d resp=%0d exp 0/0", wr_cnt, resp_cnt);
    else chk_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_in_acc();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
